// File: rtl/led_row_sprite_ctrl.sv
// Row of N_LEDS 32x32 RGB565 sprites showing a frame-rate binary counter.
// Drives the shared on/off sprite ROM pair and composites over a background.
module led_row_sprite_ctrl #(
    parameter int          N_LEDS    = 8,
    parameter int          X0        = 64,
    parameter int          Y0        = 224,
    parameter int          PITCH     = 40,
    parameter int          FRAME_DIV = 30,
    parameter logic [15:0] BG        = 16'h0000,
    parameter logic [15:0] TRANSP    = 16'h0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        hcnt,
    input  logic [9:0]        vcnt,
    input  logic              de_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              frame_stb,
    input  logic              cnt_en,
    output logic [9:0]        rom_ad,
    output logic              rom_ce,
    input  logic [15:0]       rom_on_dout,
    input  logic [15:0]       rom_off_dout,
    output logic [15:0]       rgb,
    output logic              de_out,
    output logic              hs_out,
    output logic              vs_out,
    output logic [N_LEDS-1:0] count
);

    localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int SLOT_W = 5;

    logic [DIV_W-1:0]  r_div;
    logic [N_LEDS-1:0] r_count;
    logic [N_LEDS-1:0] r_disp;

    logic [9:0]        r_col;
    logic [SLOT_W-1:0] r_slot;
    logic              r_active;
    logic [9:0]        r_ad_hold;

    logic              r_hit_d;
    logic              r_sel_d;
    logic              r_de_d;
    logic              r_hs_d;
    logic              r_vs_d;

    logic              w_at_x0;
    logic [9:0]        w_col;
    logic [SLOT_W-1:0] w_slot;
    logic              w_act;
    logic              w_vrow;
    logic [4:0]        w_vrel;
    logic              w_hit;
    logic [9:0]        w_addr;
    logic [SLOT_W-1:0] w_idx;
    logic              w_sel;
    logic [15:0]       w_pix;

    // Frame divider, counter and per-frame display latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div   <= '0;
            r_count <= '0;
            r_disp  <= '0;
        end else if (frame_stb) begin
            r_disp <= r_count;
            if (cnt_en) begin
                if (r_div == DIV_W'(FRAME_DIV - 1)) begin
                    r_div   <= '0;
                    r_count <= r_count + N_LEDS'(1);
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end
        end
    end

    assign count = r_count;

    // The X0 cycle overrides the stored column state so it can hit immediately.
    assign w_at_x0 = (hcnt == 10'(X0));
    assign w_col   = w_at_x0 ? 10'd0 : r_col;
    assign w_slot  = w_at_x0 ? '0 : r_slot;
    assign w_act   = w_at_x0 | r_active;

    assign w_vrow  = (vcnt >= 10'(Y0)) && (vcnt < 10'(Y0 + 32));
    assign w_vrel  = 5'(vcnt - 10'(Y0));
    assign w_hit   = reset_n && w_act && w_vrow && de_in && (w_col < 10'd32);
    assign w_addr  = {w_vrel, w_col[4:0]};

    assign w_idx   = SLOT_W'(N_LEDS - 1) - w_slot;
    assign w_sel   = |(r_disp & (N_LEDS'(1) << w_idx));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col    <= '0;
            r_slot   <= '0;
            r_active <= 1'b0;
        end else if (w_act) begin
            if (w_col == 10'(PITCH - 1)) begin
                r_col    <= '0;
                r_slot   <= w_slot + SLOT_W'(1);
                r_active <= (w_slot != SLOT_W'(N_LEDS - 1));
            end else begin
                r_col    <= w_col + 10'd1;
                r_slot   <= w_slot;
                r_active <= 1'b1;
            end
        end
    end

    assign rom_ce = w_hit;
    assign rom_ad = w_hit ? w_addr : r_ad_hold;

    // Stage 1 lines up with the ROM read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ad_hold <= '0;
            r_hit_d   <= 1'b0;
            r_sel_d   <= 1'b0;
            r_de_d    <= 1'b0;
            r_hs_d    <= 1'b0;
            r_vs_d    <= 1'b0;
        end else begin
            r_ad_hold <= rom_ad;
            r_hit_d   <= w_hit;
            r_sel_d   <= w_sel;
            r_de_d    <= de_in;
            r_hs_d    <= hs_in;
            r_vs_d    <= vs_in;
        end
    end

    assign w_pix = r_sel_d ? rom_on_dout : rom_off_dout;

    always_comb begin
        rgb = BG;
        if (!r_de_d)
            rgb = 16'h0000;
        else if (r_hit_d && (w_pix != TRANSP))
            rgb = w_pix;
    end

    assign de_out = r_de_d;
    assign hs_out = r_hs_d;
    assign vs_out = r_vs_d;

endmodule
